// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Width of the per-channel divide, high and phase fields.
  localparam int unsigned CFG_W = 16;

  // Smallest settle interval the lock sequencer supports.
  localparam int LOCK_CYCLES_MIN = 1;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SYNC   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  // A channel setting is usable when N >= 2, 1 <= H <= N-1 and P <= N-1.
  function automatic logic cfg_is_legal(input chan_cfg_t c);
    logic ok_s;
    ok_s = (c.div >= CFG_W'(2)) &&
           (c.high >= CFG_W'(1)) &&
           (c.high < c.div) &&
           (c.phase < c.div);
    return ok_s;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration request port of the multi-channel clock divider.
interface clk_div_multi_if #(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_W      = 16
);
  localparam int CHAN_IDX_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CHAN_IDX_W-1:0] cfg_chan;
  logic [DIV_W-1:0]      cfg_div;
  logic [DIV_W-1:0]      cfg_high;
  logic [DIV_W-1:0]      cfg_phase;
  logic                  cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: phase-preloaded counter with registered clock/enable.
module clk_div_chan
  import clk_div_pkg::*;
(
  input  logic      refclk,
  input  logic      rst_n,
  input  logic      sync,
  input  logic      run,
  input  chan_cfg_t cfg,
  output logic      outclk,
  output logic      outclk_en
);

  logic [CFG_W-1:0] cnt_r;
  logic [CFG_W-1:0] cnt_next_s;
  logic [CFG_W-1:0] load_s;
  logic             outclk_r;
  logic             outclk_en_r;

  // Preload that delays the first rising edge by P cycles after alignment.
  always_comb begin
    load_s = {CFG_W{1'b0}};
    if (cfg.phase != {CFG_W{1'b0}}) begin
      load_s = cfg.div - cfg.phase;
    end else begin
      load_s = {CFG_W{1'b0}};
    end
  end

  // Next counter value: preload on alignment, modulo-N count in run, else hold.
  always_comb begin
    cnt_next_s = cnt_r;
    if (sync) begin
      cnt_next_s = load_s;
    end else if (run) begin
      if (cnt_r >= (cfg.div - CFG_W'(1))) begin
        cnt_next_s = {CFG_W{1'b0}};
      end else begin
        cnt_next_s = cnt_r + CFG_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter and outputs; outputs track the new count so they stay (cnt < H).
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CFG_W{1'b0}};
      outclk_r    <= 1'b0;
      outclk_en_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      if (sync || run) begin
        outclk_r    <= (cnt_next_s < cfg.high);
        outclk_en_r <= (cnt_next_s == {CFG_W{1'b0}});
      end else begin
        outclk_r    <= 1'b0;
        outclk_en_r <= 1'b0;
      end
    end
  end

  assign outclk    = outclk_r;
  assign outclk_en = outclk_en_r;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/enable generator with settle-and-lock sequencing.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 4,
  parameter int DEF_HIGH    = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  enable,
  clk_div_multi_if.slave        cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int CHAN_IDX_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam int LOCK_N     = (LOCK_CYCLES < LOCK_CYCLES_MIN) ? LOCK_CYCLES_MIN : LOCK_CYCLES;
  localparam int SETTLE_W   = $clog2(LOCK_N + 1);
  localparam int FIELD_W    = (DIV_W < int'(CFG_W)) ? DIV_W : int'(CFG_W);

  state_t               state_r;
  logic [SETTLE_W-1:0]  settle_cnt_r;
  logic                 locked_r;
  logic                 ready_r;
  logic                 err_r;
  chan_cfg_t            cfg_r [NUM_CLOCKS];

  chan_cfg_t            req_s;
  logic                 chan_ok_s;
  logic                 xfer_s;
  logic                 wr_s;
  logic                 sync_s;
  logic                 run_s;

  // Assemble the incoming request and decide whether it is accepted/written.
  always_comb begin
    req_s       = '{div: {CFG_W{1'b0}}, high: {CFG_W{1'b0}}, phase: {CFG_W{1'b0}}};
    req_s.div   = CFG_W'(cfg.cfg_div[FIELD_W-1:0]);
    req_s.high  = CFG_W'(cfg.cfg_high[FIELD_W-1:0]);
    req_s.phase = CFG_W'(cfg.cfg_phase[FIELD_W-1:0]);
    chan_ok_s   = ({1'b0, cfg.cfg_chan} < (CHAN_IDX_W + 1)'(NUM_CLOCKS));
    xfer_s      = cfg.cfg_valid && ready_r;
    wr_s        = xfer_s && chan_ok_s && cfg_is_legal(req_s);
    sync_s      = (state_r == ST_SYNC);
    run_s       = (state_r == ST_RUN) && enable && !wr_s;
  end

  // Channel configuration registers, written only by an accepted legal request.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cfg_r[i] <= '{div: CFG_W'(DEF_DIV), high: CFG_W'(DEF_HIGH), phase: {CFG_W{1'b0}}};
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (wr_s && (cfg.cfg_chan == CHAN_IDX_W'(i))) begin
          cfg_r[i] <= req_s;
        end
      end
    end
  end

  // Settle / align / run sequencer with registered lock and handshake outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SETTLE;
      settle_cnt_r <= {SETTLE_W{1'b0}};
      locked_r     <= 1'b0;
      ready_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_SETTLE: begin
          locked_r <= 1'b0;
          ready_r  <= 1'b0;
          err_r    <= 1'b0;
          if (!enable) begin
            settle_cnt_r <= {SETTLE_W{1'b0}};
          end else if (settle_cnt_r == SETTLE_W'(LOCK_N - 1)) begin
            settle_cnt_r <= {SETTLE_W{1'b0}};
            state_r      <= ST_SYNC;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
          end
        end
        ST_SYNC: begin
          state_r  <= ST_RUN;
          locked_r <= 1'b1;
          ready_r  <= 1'b1;
          err_r    <= 1'b0;
        end
        ST_RUN: begin
          err_r <= xfer_s && !wr_s;
          if (wr_s || !enable) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            locked_r     <= 1'b0;
            ready_r      <= 1'b0;
          end else begin
            locked_r <= 1'b1;
            ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= {SETTLE_W{1'b0}};
          locked_r     <= 1'b0;
          ready_r      <= 1'b0;
          err_r        <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clk_div_chan u_chan (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .sync      (sync_s),
      .run       (run_s),
      .cfg       (cfg_r[g]),
      .outclk    (outclk[g]),
      .outclk_en (outclk_en[g])
    );
  end

  assign locked        = locked_r;
  assign cfg.cfg_ready = ready_r;
  assign cfg.cfg_err   = err_r;

endmodule
